// File: rtl/power_switch_emu_pkg.sv
// Shared types and helpers for the power-gate switch emulator.
// Holds the per-domain ramp state encoding and the latency/counter-load helpers.
package power_switch_emu_pkg;

  typedef enum logic [1:0] {
    PSE_ON        = 2'd0,
    PSE_RAMP_DOWN = 2'd1,
    PSE_OFF       = 2'd2,
    PSE_RAMP_UP   = 2'd3
  } pse_state_e;

  function automatic int unsigned pse_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter load value: the sampling edge itself accounts for one edge of the latency.
  function automatic int unsigned pse_load(input int unsigned lat);
    return lat - 1;
  endfunction

endpackage

// File: rtl/power_switch_emu_chan.sv
// Single power-gate switch channel: ramp FSM, down-counter, ack, abort pulse and sticky error.
module power_switch_emu_chan
  import power_switch_emu_pkg::*;
#(
  parameter int unsigned ON_LATENCY  = 16,
  parameter int unsigned OFF_LATENCY = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic switch_n_i,
  input  logic clr_err_i,
  output logic switch_ack_n_o,
  output logic domain_on_o,
  output logic busy_o,
  output logic abort_o,
  output logic err_sticky_o
);

  localparam int unsigned CNT_W = $clog2(pse_max(ON_LATENCY, OFF_LATENCY) + 1);
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(pse_load(ON_LATENCY));
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(pse_load(OFF_LATENCY));

  pse_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PSE_ON;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    abort_d = 1'b0;
    unique case (state_q)
      PSE_ON: begin
        if (switch_n_i) begin
          state_d = PSE_RAMP_DOWN;
          cnt_d   = OFF_LOAD;
        end
      end
      PSE_RAMP_DOWN: begin
        if (!switch_n_i) begin
          state_d = PSE_RAMP_UP;
          cnt_d   = ON_LOAD;
          abort_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = PSE_OFF;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PSE_OFF: begin
        if (!switch_n_i) begin
          state_d = PSE_RAMP_UP;
          cnt_d   = ON_LOAD;
        end
      end
      PSE_RAMP_UP: begin
        if (switch_n_i) begin
          state_d = PSE_RAMP_DOWN;
          cnt_d   = OFF_LOAD;
          abort_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = PSE_ON;
          ack_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = PSE_ON;
        cnt_d   = '0;
        ack_d   = 1'b0;
      end
    endcase
    // A fresh abort takes priority over a simultaneous clear.
    if (abort_d) begin
      err_d = 1'b1;
    end else if (clr_err_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_comb begin
    switch_ack_n_o = ack_q;
    abort_o        = abort_q;
    err_sticky_o   = err_q;
    domain_on_o    = (state_q == PSE_ON);
    busy_o         = (state_q == PSE_RAMP_DOWN) || (state_q == PSE_RAMP_UP);
  end

endmodule

// File: rtl/power_switch_emu.sv
// Behavioural power-gate switch emulator: one independent ramp channel per power domain,
// driving switch acks back into the chip plus bench-facing status.
module power_switch_emu
  import power_switch_emu_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 3,
  parameter int unsigned OFF_LATENCY = 16,
  parameter int unsigned ON_LATENCY  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_DOMAINS-1:0] switch_n_i,
  output logic [NUM_DOMAINS-1:0] switch_ack_n_o,
  output logic [NUM_DOMAINS-1:0] domain_on_o,
  output logic                   busy_o,
  output logic [NUM_DOMAINS-1:0] abort_o,
  output logic [NUM_DOMAINS-1:0] err_sticky_o,
  input  logic                   clr_err_i
);

  logic [NUM_DOMAINS-1:0] chan_busy;

  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_chan
    power_switch_emu_chan #(
      .ON_LATENCY (ON_LATENCY),
      .OFF_LATENCY(OFF_LATENCY)
    ) u_chan (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .switch_n_i    (switch_n_i[g]),
      .clr_err_i     (clr_err_i),
      .switch_ack_n_o(switch_ack_n_o[g]),
      .domain_on_o   (domain_on_o[g]),
      .busy_o        (chan_busy[g]),
      .abort_o       (abort_o[g]),
      .err_sticky_o  (err_sticky_o[g])
    );
  end

  always_comb begin
    busy_o = |chan_busy;
  end

endmodule

// File: tb/tb_power_switch_emu.sv
// Self-checking bench for power_switch_emu: an edge-count reference model pushes expected
// outputs into a scoreboard queue at each clock edge; they are popped and compared mid-cycle.
module tb_power_switch_emu;

  localparam int unsigned ND      = 3;
  localparam int unsigned OFF_LAT = 16;
  localparam int unsigned ON_LAT  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [ND-1:0] sw;
  logic          clr;
  logic [ND-1:0] ack, don, abrt, err;
  logic          busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct packed {
    logic [ND-1:0] ack;
    logic [ND-1:0] on;
    logic          busy;
    logic [ND-1:0] abort;
    logic [ND-1:0] err;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: edges remaining until the current ramp completes.
  bit m_ramp[ND];
  bit m_tgt[ND];
  bit m_ack[ND];
  bit m_abort[ND];
  bit m_err[ND];
  int m_left[ND];

  power_switch_emu #(
    .NUM_DOMAINS(ND),
    .OFF_LATENCY(OFF_LAT),
    .ON_LATENCY (ON_LAT)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .switch_n_i    (sw),
    .switch_ack_n_o(ack),
    .domain_on_o   (don),
    .busy_o        (busy),
    .abort_o       (abrt),
    .err_sticky_o  (err),
    .clr_err_i     (clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input bit tgt);
    return tgt ? int'(OFF_LAT) : int'(ON_LAT);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_ramp[d] = 0; m_tgt[d] = 0; m_ack[d] = 0;
      m_abort[d] = 0; m_err[d] = 0; m_left[d] = 0;
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < ND; d++) begin
      m_abort[d] = 0;
      if (!m_ramp[d]) begin
        if (sw[d] != m_ack[d]) begin
          m_ramp[d] = 1; m_tgt[d] = sw[d]; m_left[d] = lat_of(sw[d]);
        end
      end else if (sw[d] != m_tgt[d]) begin
        m_tgt[d] = sw[d]; m_left[d] = lat_of(sw[d]); m_abort[d] = 1;
      end else begin
        m_left[d]--;
        if (m_left[d] == 0) begin
          m_ramp[d] = 0; m_ack[d] = m_tgt[d];
        end
      end
      if (m_abort[d]) m_err[d] = 1;
      else if (clr)   m_err[d] = 0;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    for (int d = 0; d < ND; d++) begin
      e.ack[d]   = m_ack[d];
      e.on[d]    = !m_ramp[d] && !m_ack[d];
      e.abort[d] = m_abort[d];
      e.err[d]   = m_err[d];
      e.busy     = e.busy | m_ramp[d];
    end
    return e;
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk);
    model_edge();
    sb_q.push_back(model_out());
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("ack",   32'(ack),  32'(e.ack));
      check("on",    32'(don),  32'(e.on));
      check("busy",  32'(busy), 32'(e.busy));
      check("abort", 32'(abrt), 32'(e.abort));
      check("err",   32'(err),  32'(e.err));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; sw = '0; clr = 1'b0;
    model_reset();
    #1;
    check("rst_ack",  32'(ack),  32'h0);
    check("rst_on",   32'(don),  32'h7);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err",  32'(err),  32'h0);
    run(3);
    rst = 1'b0;
    run(100);

    // Domain 0 off (16 edges) then back on (8 edges).
    sw[0] = 1'b1; run(20);
    sw[0] = 1'b0; run(12);

    // Domain 1 off then on.
    sw[1] = 1'b1; run(20);
    sw[1] = 1'b0; run(12);

    // Domain 2 reversed mid ramp, then error cleared.
    sw[2] = 1'b1; run(5);
    sw[2] = 1'b0; run(12);
    clr = 1'b1; run(1);
    clr = 1'b0; run(3);

    // Random request/clear traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) sw[$urandom_range(0, ND-1)] ^= 1'b1;
      clr = ($urandom_range(0, 15) == 0);
      step();
    end
    clr = 1'b0; sw = '0; run(20);

    // All domains off together; domain 2 aborts with a clear on the same edge.
    sw = 3'b111; run(4);
    sw[2] = 1'b0; clr = 1'b1; run(1);
    clr = 1'b0; sw[2] = 1'b1; run(30);
    sw = '0; run(20);

    // Async reset while domain 0 ramps up (counter just loaded).
    sw[0] = 1'b1; run(17);
    sw[0] = 1'b0; run(1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_ack",  32'(ack),  32'h0);
    check("arst_on",   32'(don),  32'h7);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_err",  32'(err),  32'h0);
    run(2);
    rst = 1'b0;
    run(2);
    sw[0] = 1'b1; run(20);
    sw[0] = 1'b0; run(12);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
